// File: rtl/rmii_reply_tx_pkg.sv
// Shared types and constants for the RMII reply transmitter and its CRC32 engine.
package rmii_reply_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_FCS,
        ST_IFG
    } state_t;

    localparam logic [7:0]  PREAMBLE_BYTE     = 8'h55;
    localparam logic [7:0]  SFD_BYTE          = 8'hD5;
    localparam int          MIN_PAYLOAD_BYTES = 46;
    localparam logic [31:0] CRC_INIT          = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY_REF      = 32'hEDB8_8320;
    localparam int          FRAME_DIBITS      = 288;
    localparam int          PREAMBLE_BYTES    = 8;
    localparam int          HEADER_BYTES      = 14;
    localparam int          FCS_BYTES         = 4;

    // One reflected CRC32 step for a single input bit.
    function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic b);
        crc32_step = (crc >> 1) ^ ((crc[0] ^ b) ? CRC_POLY_REF : 32'h0);
    endfunction

    function automatic state_t next_state(input state_t st);
        case (st)
            ST_PREAMBLE: next_state = ST_HEADER;
            ST_HEADER:   next_state = ST_PAYLOAD;
            ST_PAYLOAD:  next_state = ST_FCS;
            ST_FCS:      next_state = ST_IFG;
            default:     next_state = ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/rmii_reply_tx_crc32_dibit.sv
// Ethernet CRC32 (reflected 0xEDB88320) absorbing one dibit per enabled cycle, d[0] first.
module crc32_dibit
    import rmii_reply_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        en,
    input  logic [1:0]  d,
    output logic [31:0] crc
);

    logic [31:0] r_crc;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_crc <= CRC_INIT;
        end else if (clear) begin
            r_crc <= CRC_INIT;
        end else if (en) begin
            r_crc <= crc32_step(crc32_step(r_crc, d[0]), d[1]);
        end
    end

    assign crc = r_crc;

endmodule

// File: rtl/rmii_reply_tx.sv
// RMII transmitter: one Ethernet II frame per captured bus read response.
// Build option RMII_REPLY_TX_WRITE_ACK_EN also acknowledges writes (pad byte 2 = 0x01).
module rmii_reply_tx
    import rmii_reply_tx_pkg::*;
#(
    parameter logic [47:0] FPGA_MAC  = 48'h69_69_5A_06_54_91,
    parameter logic [47:0] HOST_MAC  = 48'h00_E0_4C_68_1E_0C,
    parameter logic [15:0] ETHERTYPE = 16'h88_B5,
    parameter int          IFG_BYTES = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] rdata_i,
    input  logic        rw_i,
    input  logic        valid_i,
    output logic        txen,
    output logic [1:0]  txd,
    output logic        busy_o,
    output logic        drop_o
);

    state_t      r_state;
    logic [7:0]  r_byte_cnt;
    logic [1:0]  r_dibit_cnt;
    logic        r_txen;
    logic [1:0]  r_txd;
    logic        r_slot_full;
    logic [15:0] r_slot_data;
    logic [15:0] r_frame_data;
    logic        r_drop;

    logic         w_cap;
    logic         w_take;
    logic         w_last;
    logic         w_active;
    logic [7:0]   w_len;
    logic [7:0]   w_byte;
    logic [1:0]   w_dibit;
    logic [15:0]  w_store_data;
    logic [31:0]  w_crc;
    logic [31:0]  w_crc_n;
    logic [111:0] w_hdr;

`ifdef RMII_REPLY_TX_WRITE_ACK_EN
    logic r_slot_kind;
    logic r_frame_kind;

    assign w_cap        = valid_i;
    assign w_store_data = rw_i ? 16'h0000 : rdata_i;
`else
    assign w_cap        = valid_i && !rw_i;
    assign w_store_data = rdata_i;
`endif

    assign w_hdr    = {HOST_MAC, FPGA_MAC, ETHERTYPE};
    assign w_crc_n  = ~w_crc;
    assign w_active = (r_state == ST_PREAMBLE) || (r_state == ST_HEADER) ||
                      (r_state == ST_PAYLOAD)  || (r_state == ST_FCS);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_len = 8'(PREAMBLE_BYTES - 1);
        case (r_state)
            ST_HEADER:  w_len = 8'(HEADER_BYTES - 1);
            ST_PAYLOAD: w_len = 8'(MIN_PAYLOAD_BYTES - 1);
            ST_FCS:     w_len = 8'(FCS_BYTES - 1);
            ST_IFG:     w_len = 8'(IFG_BYTES - 1);
            default:    w_len = 8'(PREAMBLE_BYTES - 1);
        endcase
    end

    assign w_last = (r_dibit_cnt == 2'd3) && (r_byte_cnt == w_len);
    // The slot is drained either from IDLE or straight out of the IFG, so back-to-back gaps stay exact.
    assign w_take = r_slot_full && ((r_state == ST_IDLE) || ((r_state == ST_IFG) && w_last));

    always_comb begin
        w_byte = 8'h00;
        case (r_state)
            ST_PREAMBLE: w_byte = (r_byte_cnt == 8'(PREAMBLE_BYTES - 1)) ? SFD_BYTE : PREAMBLE_BYTE;
            ST_HEADER:   w_byte = w_hdr[{4'(4'd13 - r_byte_cnt[3:0]), 3'b000} +: 8];
            ST_PAYLOAD: begin
                if (r_byte_cnt == 8'd0) begin
                    w_byte = r_frame_data[15:8];
                end else if (r_byte_cnt == 8'd1) begin
                    w_byte = r_frame_data[7:0];
                end
`ifdef RMII_REPLY_TX_WRITE_ACK_EN
                else if (r_byte_cnt == 8'd2) begin
                    w_byte = {7'd0, r_frame_kind};
                end
`endif
            end
            ST_FCS:      w_byte = w_crc_n[{r_byte_cnt[1:0], 3'b000} +: 8];
            default:     w_byte = 8'h00;
        endcase
    end

    assign w_dibit = w_byte[{r_dibit_cnt, 1'b0} +: 2];

    crc32_dibit u_crc (
        .clk   (clk),
        .rst   (rst),
        .clear (r_state == ST_PREAMBLE),
        .en    ((r_state == ST_HEADER) || (r_state == ST_PAYLOAD)),
        .d     (w_dibit),
        .crc   (w_crc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_byte_cnt   <= 8'd0;
            r_dibit_cnt  <= 2'd0;
            r_txen       <= 1'b0;
            r_txd        <= 2'b00;
            r_frame_data <= 16'h0000;
`ifdef RMII_REPLY_TX_WRITE_ACK_EN
            r_frame_kind <= 1'b0;
`endif
        end else begin
            r_txen <= w_active;
            r_txd  <= w_active ? w_dibit : 2'b00;
            if (w_take) begin
                r_state      <= ST_PREAMBLE;
                r_byte_cnt   <= 8'd0;
                r_dibit_cnt  <= 2'd0;
                r_frame_data <= r_slot_data;
`ifdef RMII_REPLY_TX_WRITE_ACK_EN
                r_frame_kind <= r_slot_kind;
`endif
            end else if (r_state != ST_IDLE) begin
                if (w_last) begin
                    r_state     <= next_state(r_state);
                    r_byte_cnt  <= 8'd0;
                    r_dibit_cnt <= 2'd0;
                end else begin
                    r_dibit_cnt <= r_dibit_cnt + 2'd1;
                    if (r_dibit_cnt == 2'd3) begin
                        r_byte_cnt <= r_byte_cnt + 8'd1;
                    end
                end
            end
        end
    end

    // A capture on the draining edge refills the slot instead of counting as a drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot_full <= 1'b0;
            r_slot_data <= 16'h0000;
            r_drop      <= 1'b0;
`ifdef RMII_REPLY_TX_WRITE_ACK_EN
            r_slot_kind <= 1'b0;
`endif
        end else begin
            if (w_cap && (!r_slot_full || w_take)) begin
                r_slot_full <= 1'b1;
                r_slot_data <= w_store_data;
`ifdef RMII_REPLY_TX_WRITE_ACK_EN
                r_slot_kind <= rw_i;
`endif
            end else if (w_take) begin
                r_slot_full <= 1'b0;
            end
            if (w_cap && r_slot_full && !w_take) begin
                r_drop <= 1'b1;
            end
        end
    end

    assign txen   = r_txen;
    assign txd    = r_txd;
    assign busy_o = (r_state != ST_IDLE) || r_slot_full;
    assign drop_o = r_drop;

endmodule

// File: tb/tb_rmii_reply_tx.sv
// Self-checking bench for rmii_reply_tx: table-driven single frames plus multi-frame corner sequences.
module tb_rmii_reply_tx;

`ifdef RMII_REPLY_TX_WRITE_ACK_EN
    localparam bit WACK = 1'b1;
`else
    localparam bit WACK = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [15:0] rdata_i;
    logic        rw_i;
    logic        valid_i;
    logic        txen;
    logic [1:0]  txd;
    logic        busy_o;
    logic        drop_o;

    rmii_reply_tx dut (
        .clk     (clk),
        .rst     (rst),
        .rdata_i (rdata_i),
        .rw_i    (rw_i),
        .valid_i (valid_i),
        .txen    (txen),
        .txd     (txd),
        .busy_o  (busy_o),
        .drop_o  (drop_o)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic [575:0] bits;
        int           len;
        int           gap;
    } frame_t;

    typedef struct {
        logic        rw;
        logic [15:0] rdata;
        bit          exp_frame;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
    } vec_t;

    frame_t       mon_q[$];
    logic [575:0] cur_bits;
    int           cur_len;
    int           cur_gap;
    int           idle_cnt = 9999;
    bit           prev_txen = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    // Frame monitor: dibit k of a frame lands in bits [2k+1:2k], so byte j is bits [8j+7:8j].
    always @(negedge clk) begin
        if (txen) begin
            if (!prev_txen) begin
                cur_bits = '0;
                cur_len  = 0;
                cur_gap  = idle_cnt;
            end
            if (cur_len < 288) cur_bits[2*cur_len +: 2] = txd;
            cur_len++;
        end else begin
            if (prev_txen) begin
                mon_q.push_back('{bits: cur_bits, len: cur_len, gap: cur_gap});
                idle_cnt = 0;
            end
            idle_cnt++;
        end
        prev_txen = txen;
    end

    task automatic check(input string name, input logic [575:0] act, input logic [575:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [575:0] build_frame(input logic [7:0] b0, input logic [7:0] b1,
                                                 input logic [7:0] b2);
        logic [7:0]   by[72];
        logic [47:0]  host = 48'h00E04C681E0C;
        logic [47:0]  fpga = 48'h69695A065491;
        logic [31:0]  c;
        logic [575:0] f;
        for (int i = 0; i < 7; i++) by[i] = 8'h55;
        by[7] = 8'hD5;
        for (int i = 0; i < 6; i++) begin
            by[8+i]  = host[47-8*i -: 8];
            by[14+i] = fpga[47-8*i -: 8];
        end
        by[20] = 8'h88;
        by[21] = 8'hB5;
        by[22] = b0;
        by[23] = b1;
        by[24] = b2;
        for (int i = 25; i < 68; i++) by[i] = 8'h00;
        c = 32'hFFFFFFFF;
        for (int i = 8; i < 68; i++) begin
            c = c ^ {24'h0, by[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        for (int i = 0; i < 4; i++) by[68+i] = c[8*i +: 8];
        for (int i = 0; i < 72; i++) f[8*i +: 8] = by[i];
        return f;
    endfunction

    task automatic verify_frame(input string name, input frame_t fr, input logic [575:0] exp);
        check({name, "_len"},      fr.len,             288);
        check({name, "_preamble"}, fr.bits[63:0],      exp[63:0]);
        check({name, "_header"},   fr.bits[175:64],    exp[175:64]);
        check({name, "_payload"},  fr.bits[543:176],   exp[543:176]);
        check({name, "_fcs"},      fr.bits[575:544],   exp[575:544]);
    endtask

    // Drives a single-cycle request; returns on the negedge after the capturing edge.
    task automatic send(input logic rw, input logic [15:0] data);
        @(negedge clk);
        valid_i = 1'b1;
        rw_i    = rw;
        rdata_i = data;
        @(negedge clk);
        valid_i = 1'b0;
        rw_i    = 1'b0;
        rdata_i = 16'h0000;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while ((busy_o || txen) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check({name, "_idle"}, busy_o, 1'b0);
    endtask

    task automatic do_frame(input string name, input logic rw, input logic [15:0] data,
                            input bit exp_frame, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2);
        int     e = 0;
        frame_t fr;
        @(posedge clk);
        mon_q.delete();
        send(rw, data);
        check({name, "_busy"}, busy_o, exp_frame);
        while (!txen && e < 40) begin
            @(negedge clk);
            e++;
        end
        if (exp_frame) check({name, "_latency"}, e, 2);
        else check({name, "_no_txen"}, txen, 1'b0);
        wait_idle(name);
        check({name, "_count"}, mon_q.size(), exp_frame ? 1 : 0);
        if (exp_frame && mon_q.size() > 0) begin
            fr = mon_q.pop_front();
            verify_frame(name, fr, build_frame(b0, b1, b2));
        end
    endtask

    task automatic check_pair(input string name, input logic [7:0] a, input logic [7:0] b);
        frame_t fr;
        check({name, "_count"}, mon_q.size(), 2);
        if (mon_q.size() >= 2) begin
            fr = mon_q.pop_front();
            verify_frame({name, "_f0"}, fr, build_frame(a, a, 8'h00));
            fr = mon_q.pop_front();
            verify_frame({name, "_f1"}, fr, build_frame(b, b, 8'h00));
            check({name, "_gap"}, fr.gap, 48);
        end
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{rw: 1'b0, rdata: 16'h1234, exp_frame: 1'b1, b0: 8'h12, b1: 8'h34, b2: 8'h00};
        vecs[1] = '{rw: 1'b0, rdata: 16'h0000, exp_frame: 1'b1, b0: 8'h00, b1: 8'h00, b2: 8'h00};
        vecs[2] = '{rw: 1'b1, rdata: 16'hBEEF, exp_frame: WACK, b0: 8'h00, b1: 8'h00, b2: 8'h01};
        vecs[3] = '{rw: 1'b0, rdata: 16'hFFFF, exp_frame: 1'b1, b0: 8'hFF, b1: 8'hFF, b2: 8'h00};
        vecs[4] = '{rw: 1'b0, rdata: 16'h8001, exp_frame: 1'b1, b0: 8'h80, b1: 8'h01, b2: 8'h00};

        rst     = 1'b1;
        valid_i = 1'b0;
        rw_i    = 1'b0;
        rdata_i = 16'h0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_txen", txen, 1'b0);
        check("reset_txd",  txd,  2'b00);
        check("reset_busy", busy_o, 1'b0);
        check("reset_drop", drop_o, 1'b0);

        for (int i = 0; i < 5; i++) begin
            do_frame($sformatf("vec%0d", i), vecs[i].rw, vecs[i].rdata, vecs[i].exp_frame,
                     vecs[i].b0, vecs[i].b1, vecs[i].b2);
        end

        // Two reads one idle cycle apart.
        @(posedge clk);
        mon_q.delete();
        send(1'b0, 16'hAAAA);
        send(1'b0, 16'h5555);
        wait_idle("pair");
        check_pair("pair", 8'hAA, 8'h55);
        check("pair_drop", drop_o, 1'b0);

        // Second read lands on the edge that enters PREAMBLE for the first.
        @(posedge clk);
        mon_q.delete();
        @(negedge clk);
        valid_i = 1'b1;
        rdata_i = 16'h3C3C;
        @(negedge clk);
        rdata_i = 16'hC3C3;
        @(negedge clk);
        valid_i = 1'b0;
        rdata_i = 16'h0000;
        wait_idle("same_edge");
        check_pair("same_edge", 8'h3C, 8'hC3);
        check("same_edge_drop", drop_o, 1'b0);

        // Three reads within one frame: third is lost and drop is sticky.
        @(posedge clk);
        mon_q.delete();
        send(1'b0, 16'h1111);
        repeat (20) @(negedge clk);
        send(1'b0, 16'h2222);
        check("triple_drop_before", drop_o, 1'b0);
        send(1'b0, 16'h3333);
        check("triple_drop_set", drop_o, 1'b1);
        wait_idle("triple");
        check_pair("triple", 8'h11, 8'h22);
        repeat (10) @(negedge clk);
        check("triple_drop_sticky", drop_o, 1'b1);

        // Reset in the middle of a frame.
        begin
            int t = 0;
            send(1'b0, 16'hC0DE);
            while (!txen && t < 50) begin
                @(negedge clk);
                t++;
            end
            check("midrst_started", txen, 1'b1);
            repeat (100) @(posedge clk);
            #2 rst = 1'b1;
            #1;
            check("midrst_txen_async", txen, 1'b0);
            check("midrst_drop_clr", drop_o, 1'b0);
            repeat (3) @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            check("midrst_txen", txen, 1'b0);
            check("midrst_busy", busy_o, 1'b0);
            check("midrst_drop", drop_o, 1'b0);
        end
        do_frame("after_rst", 1'b0, 16'hC0DE, 1'b1, 8'hC0, 8'hDE, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rmii_reply_tx.md
Name: rmii_reply_tx

Overview:
- RMII Ethernet transmitter that returns bus read responses to the host.
- Sits after the last bus responder in the chain. Consumes its registered rdata/rw/valid output and emits one complete Ethernet II frame per read response on the RMII TX pins.
- Frame contents: preamble, SFD, MACs, ethertype, padded payload, CRC32 FCS, and inter-frame gap (IFG).
- Counterpart of the RMII receiver that decodes host request frames onto the bus.

Parameters:
- FPGA_MAC, 48'h69_69_5A_06_54_91, source MAC address.
- HOST_MAC, 48'h00_E0_4C_68_1E_0C, destination MAC address.
- ETHERTYPE, 16'h88_B5, ethertype field.
- IFG_BYTES, 12, idle bytes after each frame; minimum legal value 12.

Ports:
- clk  input  1  50 MHz RMII reference clock; sole clock.
- rst  input  1  asynchronous, active-high reset.
- rdata_i  input  16  read data from the bus.
- rw_i  input  1  1 = write, 0 = read.
- valid_i  input  1  bus transaction valid, single-cycle.
- txen  output  1  RMII transmit enable (registered).
- txd  output  2  RMII transmit dibit (registered).
- busy_o  output  1  high from capture until the IFG ends.
- drop_o  output  1  sticky flag: a response was lost; cleared only by rst.

Behaviour:
- Reset: txen=0, txd=2'b00, busy_o=0, drop_o=0, state IDLE, pending slot empty, CRC=32'hFFFFFFFF. Assertion mid-frame forces txen=0 immediately (asynchronous); no partial FCS is sent.
- Capture: on an edge with valid_i=1 and rw_i=0, rdata_i is latched into a one-entry pending slot.
  - If the slot is already full, the new request is discarded and drop_o is set.
  - Writes are ignored (see Optional Feature).
- Frame sequence; all bytes sent LSB first, dibit txd = byte[1:0], then [3:2], [5:4], [7:6]:
  - 7 x 0x55 preamble, then 0xD5 SFD (32 dibits).
  - HOST_MAC, then FPGA_MAC, each MSB byte first (24 dibits each).
  - ETHERTYPE, MSB byte first (8 dibits).
  - Payload: rdata[15:8], rdata[7:0], then 44 bytes of 0x00. Total 46 bytes = 184 dibits.
  - FCS: 4 bytes (16 dibits).
- txen is high for exactly 288 consecutive cycles per frame.
- FCS: standard Ethernet CRC32.
  - Reflected polynomial 0xEDB88320, init 0xFFFFFFFF.
  - Updated 2 bits per cycle over destination MAC through the last pad byte.
  - Transmitted as ~crc, bit 0 first, 2 bits per cycle.
- FSM states: IDLE -> PREAMBLE -> HEADER -> PAYLOAD -> FCS -> IFG -> IDLE.
  - Byte counter and 2-bit dibit counter reset on each state entry.
  - IFG holds txen=0 for IFG_BYTES*4 cycles.
- Latency:
  - If IDLE and the slot is filled on edge N, the FSM leaves IDLE on edge N+1 and txen rises on edge N+2.
  - A request captured during a frame is sent after that frame's IFG ends, with no further delay.
- Slot timing: the slot is emptied on the edge that enters PREAMBLE.
  - A capture on the same edge is accepted into the freed slot; no drop.
  - Back-to-back frames are therefore separated by exactly IFG_BYTES*4 idle cycles.
- busy_o = (state != IDLE) || slot full.

Optional Feature:
- Macro: RMII_REPLY_TX_WRITE_ACK_EN.
- Defined:
  - Writes (valid_i=1, rw_i=1) are also captured, with the same slot and drop rules.
  - A write produces a frame with payload bytes 0x00, 0x00, then pad byte 2 = 0x01.
  - Read frames carry 0x00 in pad byte 2.
  - The slot stores a 1-bit kind flag alongside the data.
- Undefined: writes are ignored, no kind flag exists, and pad byte 2 is always 0x00.

Decomposition:
- Shared package:
  - FSM state enum.
  - Constants: PREAMBLE_BYTE 8'h55, SFD_BYTE 8'hD5, MIN_PAYLOAD_BYTES 46, CRC_INIT 32'hFFFFFFFF, CRC_POLY_REF 32'hEDB88320, FRAME_DIBITS 288.
- One sub-module, crc32_dibit:
  - Inputs: clk, rst, clear, en, d[1:0].
  - Output: crc[31:0].
  - 2-bit-per-cycle reflected update.
  - Reused by the receiver for FCS checking.

Test Plan:
- Read valid_i=1 rw_i=0 rdata_i=16'h1234 -> txen rises 2 edges later for 288 cycles. Checks:
  - dibits 0-30 = 01; dibits 28-31 = 01,01,01,11.
  - Payload dibits encode 0x12 then 0x34; 44 zero pad bytes follow.
  - FCS equals a software CRC32 of the 60 transmitted bytes.
- Two reads 1 cycle apart (0xAAAA, 0x5555) -> two frames in order, 48 idle cycles between, drop_o=0.
- Three reads within one frame -> first two sent, third lost; drop_o=1 and stays 1 until rst.
- Write valid_i=1 rw_i=1 -> no frame without the macro. With the macro: frame with payload 0x00, 0x00, 0x01 and a correct FCS.
- rst asserted at frame cycle 100 -> txen=0 immediately. After release: idle, drop_o=0. A new read yields a full, correct 288-cycle frame.
- Read arriving on the edge the FSM enters PREAMBLE for a prior request -> accepted, sent next, no drop.
